// File: rtl/diff_enc_pkg.sv
// Shared types and default sizing for the transition-coded transmitter.
package diff_enc_pkg;

  localparam int DIFF_DATA_W    = 8;
  localparam int DIFF_STUFF_RUN = 5;

  // Bit 0 marks an emitting state, bit 1 marks the stuff state.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    STUFF = 2'b11
  } diff_state_e;

endpackage

// File: rtl/diff_bit_enc.sv
// One-bit transition encoder: a '1' on bit_in toggles the line when enabled.
module diff_bit_enc #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bit_in,
  output logic line_out
);

  logic line_q;

  // Line level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= IDLE_LEVEL;
    end else if (en) begin
      line_q <= line_q ^ bit_in;
    end else begin
      line_q <= line_q;
    end
  end

  assign line_out = line_q;

endmodule

// File: rtl/diff_enc_tx.sv
// Transition-coded serial transmitter, LSB first, one bit per clock.
// Zero-run bit stuffing is enabled by defining DIFF_ENC_TX_STUFF_EN.
module diff_enc_tx
  import diff_enc_pkg::*;
#(
  parameter int   DATA_W     = DIFF_DATA_W,
  parameter int   STUFF_RUN  = DIFF_STUFF_RUN,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              line_out,
  output logic              bit_valid,
  output logic              bit_is_stuff
);

  localparam int BL_W = $clog2(DATA_W);

  if (DATA_W < 2 || STUFF_RUN < 1) begin : g_bad_params
    $error("diff_enc_tx: DATA_W must be at least 2 and STUFF_RUN at least 1");
  end

  diff_state_e       state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic              stuff_pending;
  logic              handshake;
  logic              emit_en;
  logic              emit_bit;

`ifdef DIFF_ENC_TX_STUFF_EN
  localparam int ZR_W = $clog2(STUFF_RUN + 1);

  logic [ZR_W-1:0] zero_run_q, zero_run_d;

  assign stuff_pending = (zero_run_q == ZR_W'(STUFF_RUN));

  // Run of consecutive emitted zeros; idle cycles break the run.
  always_comb begin
    zero_run_d = zero_run_q;
    if (stuff_pending) begin
      zero_run_d = ZR_W'(0);
    end else if (emit_en) begin
      if (emit_bit) begin
        zero_run_d = ZR_W'(0);
      end else begin
        zero_run_d = zero_run_q + ZR_W'(1);
      end
    end else begin
      zero_run_d = ZR_W'(0);
    end
  end

  // Zero-run counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_run_q <= ZR_W'(0);
    end else begin
      zero_run_q <= zero_run_d;
    end
  end

  assign bit_is_stuff = (state_q == STUFF);
`else
  assign stuff_pending = 1'b0;
  assign bit_is_stuff  = 1'b0;
`endif

  assign tx_ready  = (bits_left_q == BL_W'(0)) && !stuff_pending;
  assign handshake = tx_valid && tx_ready;
  assign bit_valid = (state_q != IDLE);

  // Per-edge priority: stuff bit, remaining word bits, new word, idle.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bits_left_d = bits_left_q;
    emit_en     = 1'b0;
    emit_bit    = 1'b0;
    if (stuff_pending) begin
      emit_en  = 1'b1;
      emit_bit = 1'b1;
      state_d  = STUFF;
    end else if (bits_left_q != BL_W'(0)) begin
      emit_en     = 1'b1;
      emit_bit    = sreg_q[0];
      sreg_d      = sreg_q >> 1;
      bits_left_d = bits_left_q - BL_W'(1);
      state_d     = SHIFT;
    end else if (handshake) begin
      emit_en     = 1'b1;
      emit_bit    = tx_data[0];
      sreg_d      = tx_data >> 1;
      bits_left_d = BL_W'(DATA_W - 1);
      state_d     = SHIFT;
    end else begin
      state_d = IDLE;
    end
  end

  // Shifter, bit counter and state registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bits_left_q <= BL_W'(0);
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bits_left_q <= bits_left_d;
    end
  end

  diff_bit_enc #(
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_bit_enc (
    .clk     (clk),
    .rst     (rst),
    .en      (emit_en),
    .bit_in  (emit_bit),
    .line_out(line_out)
  );

endmodule

// File: tb/tb_diff_enc_tx.sv
// Bench for diff_enc_tx: table vectors, corner sequences and a randomized run
// checked against a queue-based bit-stream model with XOR loopback decoding.
module tb_diff_enc_tx;

  localparam int DATA_W    = 8;
  localparam int STUFF_RUN = 5;
`ifdef DIFF_ENC_TX_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              line_out;
  logic              bit_valid;
  logic              bit_is_stuff;

  always #5 clk = ~clk;

  diff_enc_tx #(
    .DATA_W    (DATA_W),
    .STUFF_RUN (STUFF_RUN),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .line_out    (line_out),
    .bit_valid   (bit_valid),
    .bit_is_stuff(bit_is_stuff)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending emissions {stuff, bit}, and data bits awaiting loopback.
  bit [1:0] pend[$];
  bit       txbits[$];
  bit       m_level;
  bit       m_valid;
  bit       m_stuff;
  int       zc;
  bit       synced = 1'b0;
  logic     prev_line;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [DATA_W-1:0] d);
    bit [1:0] e;
    if (r) begin
      pend.delete();
      txbits.delete();
      m_level = 1'b0;
      m_valid = 1'b0;
      m_stuff = 1'b0;
      zc      = 0;
    end else begin
      if (pend.size() == 0 && v) begin
        for (int i = 0; i < DATA_W; i++) begin
          pend.push_back({1'b0, d[i]});
          txbits.push_back(d[i]);
          if (d[i]) begin
            zc = 0;
          end else begin
            zc++;
            if (STUFF_EN && zc == STUFF_RUN) begin
              pend.push_back(2'b11);
              zc = 0;
            end
          end
        end
      end
      if (pend.size() > 0) begin
        e = pend.pop_front();
        m_level = m_level ^ e[0];
        m_valid = 1'b1;
        m_stuff = e[1];
      end else begin
        m_valid = 1'b0;
        m_stuff = 1'b0;
        zc      = 0;
      end
    end
  endtask

  // One clock: capture inputs, advance, update model, compare, decode loopback.
  task automatic step();
    logic              r;
    logic              v;
    logic [DATA_W-1:0] d;
    bit                exp_bit;
    r = rst;
    v = tx_valid;
    d = tx_data;
    @(posedge clk);
    #1;
    if (r) synced = 1'b1;
    model_edge(r, v, d);
    if (synced) begin
      check("model_line_out", line_out, m_level);
      check("model_bit_valid", bit_valid, m_valid);
      check("model_bit_is_stuff", bit_is_stuff, m_stuff);
      check("model_tx_ready", tx_ready, (pend.size() == 0));
      if (!r && bit_valid === 1'b1 && bit_is_stuff === 1'b0) begin
        if (txbits.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL loopback_extra_bit actual=1 expected=0 at %0t", $time);
        end else begin
          exp_bit = txbits.pop_front();
          check("loopback_bit", line_out ^ prev_line, exp_bit);
        end
      end
    end
    prev_line = line_out;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [7:0]        exp_line;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] line_seq;
    int         nvalid;
    int         nready_low;
    int         toggles;
    int         first_v;
    int         last_v;
    int         nstuff;
    int         stuff_idx;
    logic       stuff_line;
    logic       stuff_ready;
    logic       seen;
    logic       held;
    int         changes;

    vecs[0] = '{8'hA5, 8'h63};
    vecs[1] = '{8'hFF, 8'h55};
    vecs[2] = '{8'h5A, 8'h36};
    vecs[3] = '{8'h33, 8'h11};
    vecs[4] = '{8'hF0, 8'h50};

    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    prev_line = 1'b0;

    do_reset();
    check("reset_line_out", line_out, 1'b0);
    check("reset_bit_valid", bit_valid, 1'b0);
    check("reset_tx_ready", tx_ready, 1'b1);
    check("reset_bit_is_stuff", bit_is_stuff, 1'b0);

    // Single words from idle: line level sequence and ready window.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      tx_data  = vecs[i].data;
      tx_valid = 1'b1;
      step();
      tx_valid   = 1'b0;
      line_seq   = 8'h00;
      nvalid     = 0;
      nready_low = 0;
      for (int k = 0; k < 8; k++) begin
        line_seq[k] = line_out;
        nvalid      = nvalid + int'(bit_valid);
        nready_low  = nready_low + int'(!tx_ready);
        tx_data     = DATA_W'($urandom);
        if (k < 7) step();
      end
      check("vec_line_seq", line_seq, vecs[i].exp_line);
      check("vec_bit_valid_count", nvalid, 8);
      check("vec_ready_low_cycles", nready_low, 7);
      step();
      check("vec_idle_after_word", bit_valid, 1'b0);
    end

    // Back-to-back 0xFF then 0x00 with tx_valid held.
    do_reset();
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    step();
    tx_data     = 8'h00;
    nvalid      = 0;
    toggles     = 0;
    first_v     = -1;
    last_v      = -1;
    nstuff      = 0;
    stuff_idx   = -1;
    stuff_line  = 1'b0;
    stuff_ready = 1'b1;
    seen        = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (bit_valid) begin
        nvalid++;
        if (first_v < 0) first_v = k;
        last_v = k;
      end
      if (line_out !== seen) toggles++;
      seen = line_out;
      if (bit_is_stuff) begin
        nstuff++;
        stuff_idx   = k;
        stuff_line  = line_out;
        stuff_ready = tx_ready;
      end
      if (k == 8) tx_valid = 1'b0;
      if (k < 24) step();
    end
    check("b2b_valid_count", nvalid, STUFF_EN ? 17 : 16);
    check("b2b_valid_span", last_v - first_v + 1, STUFF_EN ? 17 : 16);
    check("b2b_toggles", toggles, STUFF_EN ? 9 : 8);
    check("b2b_final_line", line_out, STUFF_EN ? 1'b1 : 1'b0);
    check("b2b_stuff_count", nstuff, STUFF_EN ? 1 : 0);
`ifdef DIFF_ENC_TX_STUFF_EN
    check("b2b_stuff_position", stuff_idx, 13);
    check("b2b_stuff_line", stuff_line, 1'b1);
    check("b2b_stuff_ready", stuff_ready, 1'b0);
`endif

    // Reset after three bits of 0x3C aborts the word.
    do_reset();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    step();
    check("abort_pre_line", line_out, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_line_out", line_out, 1'b0);
    check("abort_bit_valid", bit_valid, 1'b0);
    check("abort_tx_ready", tx_ready, 1'b1);
    held    = line_out;
    changes = 0;
    nvalid  = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (line_out !== held) changes++;
      nvalid = nvalid + int'(bit_valid);
    end
    check("abort_idle_line_changes", changes, 0);
    check("abort_idle_bit_valid", nvalid, 0);

    // Randomized traffic, zero-heavy words included to exercise stuffing.
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      tx_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        tx_data = DATA_W'($urandom);
      end else begin
        tx_data = DATA_W'($urandom) & DATA_W'($urandom) & DATA_W'($urandom);
      end
      step();
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    for (int n = 0; n < 20; n++) step();
    check("loopback_drained", txbits.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
